// File: rtl/memory_turn_ctrl.sv
// Turn sequencer for the two-player memory game: validates selections, drives the card bank
// strobes, scores pairs. Optional turn time limit is built when TURN_TIMEOUT_EN is defined.
package memory_turn_pkg;
  typedef enum logic [1:0] {CARD_DOWN = 2'd0, CARD_UP = 2'd1, CARD_MATCH = 2'd2} card_state_e;
  typedef enum logic [2:0] {
    ST_IDLE, ST_WAIT_FIRST, ST_WAIT_SECOND, ST_COMPARE, ST_SHOW_MISS, ST_DONE
  } turn_state_e;
endpackage

module memory_turn_ctrl
  import memory_turn_pkg::*;
#(
  parameter int SHOW_CYCLES = 50_000_000,
  parameter int TURN_CYCLES = 750_000_000,
  parameter int NUM_PAIRS   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sel_valid,
  input  logic [3:0]  sel_idx,
  input  card_state_e card_state [16],
  input  logic [3:0]  card_sym [16],
  output logic        new_game,
  output logic        open_en,
  output logic [3:0]  open_idx,
  output logic        close_pair_en,
  output logic [3:0]  close_a,
  output logic [3:0]  close_b,
  output logic        lock_pair_en,
  output logic [3:0]  lock_a,
  output logic [3:0]  lock_b,
  output logic        cur_player,
  output logic [3:0]  score0,
  output logic [3:0]  score1,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic        timeout,
  output turn_state_e dbg_state
);

  localparam int SHOW_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [SHOW_W-1:0] SHOW_LOAD = SHOW_W'(SHOW_CYCLES - 1);

  if (SHOW_CYCLES < 1 || TURN_CYCLES < 1 || NUM_PAIRS < 1 || NUM_PAIRS > 8) begin : g_param_check
    $error("memory_turn_ctrl: illegal parameter value");
  end

  turn_state_e       state_q, state_d;
  logic [3:0]        first_q, first_d, second_q, second_d;
  logic [SHOW_W-1:0] hold_q, hold_d;
  logic [3:0]        pairs_q, pairs_d;
  logic              player_q, player_d;
  logic [3:0]        score0_q, score0_d, score1_q, score1_d;
  logic              new_game_q, new_game_d, open_en_q, open_en_d;
  logic [3:0]        open_idx_q, open_idx_d;
  logic              close_en_q, close_en_d, lock_en_q, lock_en_d;
  logic [3:0]        close_a_q, close_a_d, close_b_q, close_b_d;
  logic [3:0]        lock_a_q, lock_a_d, lock_b_q, lock_b_d;
  logic              game_over_q, game_over_d, timeout_q, timeout_d;
  logic [1:0]        winner_q, winner_d;
  logic              sel_ok, turn_expired;

  // The bank reports CARD_UP only two cycles after a pick, so the first index is checked directly.
  assign sel_ok = sel_valid && (card_state[sel_idx] == CARD_DOWN);

  always_comb begin
    state_d    = state_q;
    first_d    = first_q;
    second_d   = second_q;
    hold_d     = hold_q;
    pairs_d    = pairs_q;
    player_d   = player_q;
    score0_d   = score0_q;
    score1_d   = score1_q;
    new_game_d = 1'b0;
    open_en_d  = 1'b0;
    open_idx_d = open_idx_q;
    close_en_d = 1'b0;
    close_a_d  = close_a_q;
    close_b_d  = close_b_q;
    lock_en_d  = 1'b0;
    lock_a_d   = lock_a_q;
    lock_b_d   = lock_b_q;
    timeout_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          new_game_d = 1'b1;
          score0_d   = '0;
          score1_d   = '0;
          pairs_d    = '0;
          player_d   = 1'b0;
          state_d    = ST_WAIT_FIRST;
        end
      end
      ST_WAIT_FIRST: begin
        if (sel_ok) begin
          first_d    = sel_idx;
          open_en_d  = 1'b1;
          open_idx_d = sel_idx;
          state_d    = ST_WAIT_SECOND;
        end else if (turn_expired) begin
          timeout_d = 1'b1;
          player_d  = ~player_q;
        end
      end
      ST_WAIT_SECOND: begin
        if (sel_ok && (sel_idx != first_q)) begin
          second_d   = sel_idx;
          open_en_d  = 1'b1;
          open_idx_d = sel_idx;
          state_d    = ST_COMPARE;
        end else if (turn_expired) begin
          timeout_d  = 1'b1;
          close_en_d = 1'b1;
          close_a_d  = first_q;
          close_b_d  = first_q;
          player_d   = ~player_q;
          state_d    = ST_WAIT_FIRST;
        end
      end
      ST_COMPARE: begin
        if (card_sym[first_q] == card_sym[second_q]) begin
          lock_en_d = 1'b1;
          lock_a_d  = first_q;
          lock_b_d  = second_q;
          if (!player_q && score0_q < 4'(NUM_PAIRS)) score0_d = score0_q + 4'd1;
          if (player_q && score1_q < 4'(NUM_PAIRS)) score1_d = score1_q + 4'd1;
          pairs_d = pairs_q + 4'd1;
          state_d = (pairs_q + 4'd1 == 4'(NUM_PAIRS)) ? ST_DONE : ST_WAIT_FIRST;
        end else begin
          hold_d  = SHOW_LOAD;
          state_d = ST_SHOW_MISS;
        end
      end
      ST_SHOW_MISS: begin
        if (hold_q == '0) begin
          close_en_d = 1'b1;
          close_a_d  = first_q;
          close_b_d  = second_q;
          player_d   = ~player_q;
          state_d    = ST_WAIT_FIRST;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    game_over_d = (state_d == ST_DONE);
    winner_d    = 2'd0;
    if (state_d == ST_DONE) begin
      if (score0_d > score1_d)      winner_d = 2'd1;
      else if (score1_d > score0_d) winner_d = 2'd2;
      else                          winner_d = 2'd3;
    end
  end

`ifdef TURN_TIMEOUT_EN
  localparam int TURN_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam logic [TURN_W-1:0] TURN_LOAD = TURN_W'(TURN_CYCLES - 1);
  logic [TURN_W-1:0] turn_q, turn_d;
  logic              in_wait;

  assign in_wait      = (state_q == ST_WAIT_FIRST) || (state_q == ST_WAIT_SECOND);
  assign turn_expired = in_wait && (turn_q == '0);

  // Reload on every accepted pick, on entering WAIT_FIRST, and after a WAIT_FIRST expiry.
  always_comb begin
    turn_d = turn_q;
    if (open_en_d || (state_d == ST_WAIT_FIRST && (state_q != ST_WAIT_FIRST || timeout_d)))
      turn_d = TURN_LOAD;
    else if (in_wait)
      turn_d = turn_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) turn_q <= '0;
    else     turn_q <= turn_d;
  end
`else
  assign turn_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      first_q     <= '0;
      second_q    <= '0;
      hold_q      <= '0;
      pairs_q     <= '0;
      player_q    <= 1'b0;
      score0_q    <= '0;
      score1_q    <= '0;
      new_game_q  <= 1'b0;
      open_en_q   <= 1'b0;
      open_idx_q  <= '0;
      close_en_q  <= 1'b0;
      close_a_q   <= '0;
      close_b_q   <= '0;
      lock_en_q   <= 1'b0;
      lock_a_q    <= '0;
      lock_b_q    <= '0;
      game_over_q <= 1'b0;
      winner_q    <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      first_q     <= first_d;
      second_q    <= second_d;
      hold_q      <= hold_d;
      pairs_q     <= pairs_d;
      player_q    <= player_d;
      score0_q    <= score0_d;
      score1_q    <= score1_d;
      new_game_q  <= new_game_d;
      open_en_q   <= open_en_d;
      open_idx_q  <= open_idx_d;
      close_en_q  <= close_en_d;
      close_a_q   <= close_a_d;
      close_b_q   <= close_b_d;
      lock_en_q   <= lock_en_d;
      lock_a_q    <= lock_a_d;
      lock_b_q    <= lock_b_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
      timeout_q   <= timeout_d;
    end
  end

  assign new_game      = new_game_q;
  assign open_en       = open_en_q;
  assign open_idx      = open_idx_q;
  assign close_pair_en = close_en_q;
  assign close_a       = close_a_q;
  assign close_b       = close_b_q;
  assign lock_pair_en  = lock_en_q;
  assign lock_a        = lock_a_q;
  assign lock_b        = lock_b_q;
  assign cur_player    = player_q;
  assign score0        = score0_q;
  assign score1        = score1_q;
  assign game_over     = game_over_q;
  assign winner        = winner_q;
  assign timeout       = timeout_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_memory_turn_ctrl.sv
// Bench for memory_turn_ctrl: behavioural card bank, strobe scoreboard keyed by cycle,
// table-driven game script plus reset and (with TURN_TIMEOUT_EN) timeout sequences.
module tb_memory_turn_ctrl;
  import memory_turn_pkg::*;

  localparam int SHOW = 4;
  localparam int TURN = 20;
  localparam int EW   = 27;

  // Event kinds carried in the scoreboard entries.
  localparam logic [2:0] K_OPEN = 3'd0, K_CLOSE = 3'd1, K_LOCK = 3'd2, K_NEW = 3'd3, K_TMO = 3'd4;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, sel_valid = 1'b0;
  logic [3:0]  sel_idx = 4'd0;
  card_state_e card_state [16];
  logic [3:0]  card_sym [16];
  logic        new_game, open_en, close_pair_en, lock_pair_en, cur_player, game_over, timeout;
  logic [3:0]  open_idx, close_a, close_b, lock_a, lock_b, score0, score1;
  logic [1:0]  winner;
  turn_state_e dbg_state;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];
  logic          have_first = 1'b0;
  logic [3:0]    first_i = 4'd0;

  typedef struct {
    logic [3:0] idx;
    logic       acc;
    int         gap;
    logic       pl;
    logic [3:0] s0;
    logic [3:0] s1;
  } vec_t;
  vec_t vecs [26];

  memory_turn_ctrl #(.SHOW_CYCLES(SHOW), .TURN_CYCLES(TURN), .NUM_PAIRS(8)) dut (
    .clk(clk), .rst(rst), .start(start), .sel_valid(sel_valid), .sel_idx(sel_idx),
    .card_state(card_state), .card_sym(card_sym),
    .new_game(new_game), .open_en(open_en), .open_idx(open_idx),
    .close_pair_en(close_pair_en), .close_a(close_a), .close_b(close_b),
    .lock_pair_en(lock_pair_en), .lock_a(lock_a), .lock_b(lock_b),
    .cur_player(cur_player), .score0(score0), .score1(score1),
    .game_over(game_over), .winner(winner), .timeout(timeout), .dbg_state(dbg_state)
  );

  // clock / cycle counter / bank model
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rst || new_game) begin
      for (int i = 0; i < 16; i++) card_state[i] <= CARD_DOWN;
    end else begin
      if (open_en) card_state[open_idx] <= CARD_UP;
      if (close_pair_en) begin
        card_state[close_a] <= CARD_DOWN;
        card_state[close_b] <= CARD_DOWN;
      end
      if (lock_pair_en) begin
        card_state[lock_a] <= CARD_MATCH;
        card_state[lock_b] <= CARD_MATCH;
      end
    end
  end

  function automatic logic [EW-1:0] mk(input int c, input logic [2:0] k,
                                       input logic [3:0] a, input logic [3:0] b);
    return {16'(c), k, a, b};
  endfunction

  task automatic push_evt(input int c, input logic [2:0] k, input logic [3:0] a, input logic [3:0] b);
    exp_q.push_back(mk(c, k, a, b));
  endtask

  task automatic check_evt(input logic [2:0] k, input logic [3:0] a, input logic [3:0] b);
    logic [EW-1:0] got, exp;
    got = mk(cyc, k, a, b);
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL evt_unexpected got kind=%0d cyc=%0d a=%0d b=%0d required no event", k, cyc, a, b);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        n_err++;
        $display("FAIL evt got kind=%0d cyc=%0d a=%0d b=%0d required kind=%0d cyc=%0d a=%0d b=%0d",
                 k, cyc, a, b, exp[10:8], exp[26:11], exp[7:4], exp[3:0]);
      end
    end
  endtask

  // strobe monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (new_game)      check_evt(K_NEW, 4'd0, 4'd0);
    if (open_en)       check_evt(K_OPEN, open_idx, 4'd0);
    if (close_pair_en) check_evt(K_CLOSE, close_a, close_b);
    if (lock_pair_en)  check_evt(K_LOCK, lock_a, lock_b);
    if (timeout)       check_evt(K_TMO, 4'd0, 4'd0);
    if (open_en) begin
      n_cmp++;
      if (close_pair_en || lock_pair_en) begin
        n_err++;
        $display("FAIL open_exclusive got close=%0b lock=%0b with open required 0/0",
                 close_pair_en, lock_pair_en);
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d required %0d", nm, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " state"}, int'(dbg_state), int'(ST_IDLE));
    chk({tag, " strobes"}, {new_game, open_en, close_pair_en, lock_pair_en, timeout}, 0);
    chk({tag, " indices"}, {open_idx, close_a, close_b, lock_a, lock_b}, 0);
    chk({tag, " cur_player"}, cur_player, 0);
    chk({tag, " score0"}, score0, 0);
    chk({tag, " score1"}, score1, 0);
    chk({tag, " game_over"}, game_over, 0);
    chk({tag, " winner"}, winner, 0);
  endtask

  // drivers
  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    push_evt(cyc, K_NEW, 4'd0, 4'd0);
    start = 1'b0;
    have_first = 1'b0;
  endtask

  task automatic do_sel(input logic [3:0] idx, input logic acc, output int c);
    @(negedge clk);
    sel_valid = 1'b1;
    sel_idx   = idx;
    @(posedge clk);
    #1;
    c = cyc;
    sel_valid = 1'b0;
    if (acc) begin
      push_evt(c, K_OPEN, idx, 4'd0);
      if (have_first) begin
        if (card_sym[first_i] == card_sym[idx]) push_evt(c + 1, K_LOCK, first_i, idx);
        else                                    push_evt(c + SHOW + 1, K_CLOSE, first_i, idx);
        have_first = 1'b0;
      end else begin
        have_first = 1'b1;
        first_i    = idx;
      end
    end
  endtask

  task automatic set_v(input int i, input logic [3:0] idx, input logic acc, input int gap,
                       input logic pl, input logic [3:0] s0, input logic [3:0] s1);
    vecs[i] = '{idx, acc, gap, pl, s0, s1};
  endtask

  initial begin
    int c;
    for (int i = 0; i < 16; i++) card_sym[i] = 4'(i >> 1);
    // idx, accepted, idle gap, then player/score0/score1 checked after the gap
    set_v(0,  4'd0,  1, 0, 0, 0, 0);  set_v(1,  4'd1,  1, 3, 0, 1, 0);
    set_v(2,  4'd2,  1, 0, 0, 0, 0);  set_v(3,  4'd4,  1, 8, 1, 1, 0);
    set_v(4,  4'd5,  1, 0, 0, 0, 0);  set_v(5,  4'd5,  0, 0, 0, 0, 0);
    set_v(6,  4'd0,  0, 0, 0, 0, 0);  set_v(7,  4'd3,  1, 0, 0, 0, 0);
    set_v(8,  4'd6,  0, 0, 0, 0, 0);  set_v(9,  4'd7,  0, 7, 0, 1, 0);
    set_v(10, 4'd2,  1, 0, 0, 0, 0);  set_v(11, 4'd3,  1, 3, 0, 2, 0);
    set_v(12, 4'd4,  1, 0, 0, 0, 0);  set_v(13, 4'd5,  1, 3, 0, 3, 0);
    set_v(14, 4'd6,  1, 0, 0, 0, 0);  set_v(15, 4'd7,  1, 3, 0, 4, 0);
    set_v(16, 4'd8,  1, 0, 0, 0, 0);  set_v(17, 4'd9,  1, 3, 0, 5, 0);
    set_v(18, 4'd10, 1, 0, 0, 0, 0);  set_v(19, 4'd12, 1, 8, 1, 5, 0);
    set_v(20, 4'd10, 1, 0, 0, 0, 0);  set_v(21, 4'd11, 1, 3, 1, 5, 1);
    set_v(22, 4'd12, 1, 0, 0, 0, 0);  set_v(23, 4'd13, 1, 3, 1, 5, 2);
    set_v(24, 4'd14, 1, 0, 0, 0, 0);  set_v(25, 4'd15, 1, 3, 1, 5, 3);

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;

    do_start();
    for (int i = 0; i < 26; i++) begin
      do_sel(vecs[i].idx, vecs[i].acc, c);
      if (vecs[i].gap > 0) begin
        repeat (vecs[i].gap) @(posedge clk);
        @(negedge clk);
        chk($sformatf("row%0d cur_player", i), cur_player, vecs[i].pl);
        chk($sformatf("row%0d score0", i), score0, vecs[i].s0);
        chk($sformatf("row%0d score1", i), score1, vecs[i].s1);
      end
    end
    @(negedge clk);
    chk("done game_over", game_over, 1);
    chk("done winner", winner, 1);
    chk("done state", int'(dbg_state), int'(ST_DONE));

    do_start();
    @(negedge clk);
    chk("restart score0", score0, 0);
    chk("restart score1", score1, 0);
    chk("restart game_over", game_over, 0);
    chk("restart winner", winner, 0);
    chk("restart cur_player", cur_player, 0);

    // reset while a mismatched pair is being shown: the pending close must never appear
    do_sel(4'd0, 1'b1, c);
    do_sel(4'd2, 1'b1, c);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("pre_reset state", int'(dbg_state), int'(ST_SHOW_MISS));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset("mid_show_reset");
    chk("pending_close", exp_q.size(), 1);
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    have_first = 1'b0;
    repeat (10) @(posedge clk);

`ifdef TURN_TIMEOUT_EN
    do_start();
    do_sel(4'd6, 1'b1, c);
    push_evt(c + TURN, K_CLOSE, 4'd6, 4'd6);
    push_evt(c + TURN, K_TMO, 4'd0, 4'd0);
    have_first = 1'b0;
    repeat (TURN + 3) @(posedge clk);
    @(negedge clk);
    chk("timeout cur_player", cur_player, 1);
    chk("timeout state", int'(dbg_state), int'(ST_WAIT_FIRST));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
`endif

    @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/memory_turn_ctrl.md
# memory_turn_ctrl

Turn sequencer for the two-player memory game. It accepts card selections from the input/cursor logic and validates them against the card bank's live state. It drives the bank's open, close-pair and lock-pair strobes, holds a mismatched pair visible for a fixed time, and keeps per-player scores, turn ownership and end-of-game status. It sits between the input decoder and the card bank, and its status outputs feed the VGA/score renderer.

## Interface
- `SHOW_CYCLES`, default 50_000_000: cycles a mismatched pair stays face-up (1 s at 50 MHz); must be ≥1.
- `TURN_CYCLES`, default 750_000_000: turn time limit in cycles. Used only with `TURN_TIMEOUT_EN`.
- `NUM_PAIRS`, default 8: pairs needed to end the game.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: pulse; starts a new game from IDLE or DONE.
- `sel_valid` in 1: pulse; player selects card `sel_idx`.
- `sel_idx` in 4: selected card index.
- `card_state` in `card_state_e [16]`: live state per card, from the bank.
- `card_sym` in 4×16: symbol id per card, from the bank.
- `new_game` out 1: one-cycle pulse; top ORs it into the bank reset.
- `open_en` out 1: bank open strobe.
- `open_idx` out 4: card to open.
- `close_pair_en` out 1: bank close-pair strobe.
- `close_a`, `close_b` out 4 each: cards to close.
- `lock_pair_en` out 1: bank lock-pair strobe.
- `lock_a`, `lock_b` out 4 each: cards to lock.
- `cur_player` out 1: player whose turn it is (0/1).
- `score0`, `score1` out 4 each: pairs won per player.
- `game_over` out 1: high in DONE.
- `winner` out 2: 0 = none, 1 = P0, 2 = P1, 3 = tie; valid when `game_over` is high.
- `timeout` out 1: one-cycle pulse on turn expiry.

## Operation
- FSM states: IDLE, WAIT_FIRST, WAIT_SECOND, COMPARE, SHOW_MISS, DONE.
- **IDLE**
  - On `start`: pulse `new_game`, clear scores, pair count and `cur_player`, then go to WAIT_FIRST.
- **Accepted selection**: `sel_valid` in a WAIT state with `card_state[sel_idx]==CARD_DOWN`. In WAIT_SECOND, `sel_idx` must also differ from the latched first index. All other selections are ignored with no output activity.
- **WAIT_FIRST**
  - Accepted selection: latch `first_idx`, pulse `open_en`/`open_idx`, go to WAIT_SECOND.
- **WAIT_SECOND**
  - Accepted selection: latch `second_idx`, pulse `open_en`, go to COMPARE.
- **COMPARE** (one cycle)
  - **Match** (`card_sym[first]==card_sym[second]`):
    - Pulse `lock_pair_en` with `lock_a=first`, `lock_b=second`.
    - Increment the current player's score and the pair count.
    - If the new pair count equals `NUM_PAIRS`, go to DONE; otherwise go to WAIT_FIRST with the same player.
  - **Mismatch**: load the hold counter with `SHOW_CYCLES-1` and go to SHOW_MISS.
- **SHOW_MISS**
  - Decrement the counter. When it is 0: pulse `close_pair_en` (`close_a=first`, `close_b=second`), toggle `cur_player`, go to WAIT_FIRST.
- **DONE**
  - `game_over`=1. `winner` is the higher score, or 3 on equal scores.
  - `start` behaves as in IDLE.
- `start` is ignored outside IDLE and DONE.
- `sel_valid` is ignored outside the WAIT states.
- Scores never exceed `NUM_PAIRS`; no wrap.

## Timing
- All outputs are registered. Strobes are high for exactly one cycle, in the cycle after the triggering edge.
- Selection sampled at edge t → `open_en` high during cycle t+1 → bank shows CARD_UP from t+2.
  - Because the bank state lags, the first-index check in WAIT_SECOND is mandatory.
- Second selection at edge t:
  - COMPARE occupies cycle t+1.
  - `lock_pair_en` (match) is high during t+2.
  - On a mismatch, `close_pair_en` is high during t+2+`SHOW_CYCLES`.
- `open_en` and `lock_pair_en`/`close_pair_en` are never high in the same cycle.
- Reset values:
  - State IDLE.
  - All strobes 0.
  - All indices 0.
  - `cur_player`=0, scores 0, `game_over`=0, `winner`=0, `timeout`=0.
- `rst` mid-game aborts immediately to IDLE. It does not pulse `new_game`; the bank receives `rst` directly.

## Configuration
- `TURN_TIMEOUT_EN` defined:
  - A turn counter reloads to `TURN_CYCLES-1` on entry to WAIT_FIRST and on every accepted selection, and decrements in the WAIT states.
  - **Expiry in WAIT_FIRST**: pulse `timeout`, toggle `cur_player`, reload the counter.
  - **Expiry in WAIT_SECOND**: pulse `timeout`, pulse `close_pair_en` with `close_a=close_b=first_idx`, toggle `cur_player`, go to WAIT_FIRST.
- Not defined: no turn counter is present; `timeout` is tied to 0; the WAIT states wait indefinitely.

## Test plan
Bank ids 0,0,1,1,…,7,7; `SHOW_CYCLES`=4; `TURN_CYCLES`=20.
- **Start and match.** Stimulus: `start`, then select 0, then 1. Response: `open_en` idx 0, then idx 1; `lock_pair_en` (0,1) two cycles after the second select; `score0`=1; `cur_player` stays 0.
- **Mismatch.** Stimulus: select 2, then 4. Response: `close_pair_en` (2,4) exactly 6 cycles after the second select; `cur_player`=1; scores unchanged.
- **Rejected selections.**
  - Re-select the first card one cycle after it was picked: no `open_en`.
  - Select a CARD_MATCH card: no `open_en`.
  - `sel_valid` during SHOW_MISS: no effect.
- **Full game.** Stimulus: P0 matches 5 pairs, P1 matches 3. Response: `game_over`=1, `winner`=1. A following `start` pulses `new_game` and clears the scores.
- **Reset mid-SHOW_MISS.** Response: all outputs return to reset values the next cycle; no `close_pair_en` is issued.
- **Turn timeout** (`TURN_TIMEOUT_EN`). Stimulus: select 6, then idle 20 cycles. Response: `timeout` pulses; `close_pair_en` with `close_a=close_b=6`; `cur_player` toggles.
